// File: rtl/serial_rxtx_fifo_leds.sv
// serial_rxtx_fifo_leds: UART echo with per-byte transform, TX FIFO, overflow flag and LED drive
module async_receiver #(
  parameter int ClkFrequency = 24000000,
  parameter int Baud = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic       RxD_data_ready,
  output logic [7:0] RxD_data
);
  localparam int Div = ClkFrequency / Baud;
  logic [1:0] sync;
  logic act, rdy;
  logic [7:0] sh;
  logic [15:0] cnt;
  logic [3:0] n;
  assign RxD_data_ready = rdy;
  assign RxD_data = sh;
  // bit 0 is the start bit re-checked at mid-bit, bits 1..8 data LSB first, bit 9 stop
  always_ff @(posedge clk)
    if (rst) begin
      sync <= 2'b11;
      act <= 1'b0;
      rdy <= 1'b0;
      sh <= '0;
      cnt <= '0;
      n <= '0;
    end else begin
      sync <= {sync[0], RxD};
      rdy <= 1'b0;
      if (!act) begin
        if (!sync[1]) begin
          act <= 1'b1;
          cnt <= 16'(Div / 2 - 1);
          n <= '0;
        end
      end else if (cnt != '0) cnt <= cnt - 16'd1;
      else begin
        cnt <= 16'(Div - 1);
        n <= n + 4'd1;
        if (n == 4'd0 && sync[1]) act <= 1'b0;
        else if (n == 4'd9) begin
          act <= 1'b0;
          rdy <= sync[1];
        end else if (n != 4'd0) sh <= {sync[1], sh[7:1]};
      end
    end
endmodule

module async_transmitter #(
  parameter int ClkFrequency = 24000000,
  parameter int Baud = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD,
  output logic       TxD_busy
);
  localparam int Div = ClkFrequency / Baud;
  logic run;
  logic [9:0] sh;
  logic [15:0] cnt;
  logic [3:0] n;
  assign TxD = run ? sh[0] : 1'b1;
  assign TxD_busy = run;
  always_ff @(posedge clk)
    if (rst) begin
      run <= 1'b0;
      sh <= '1;
      cnt <= '0;
      n <= '0;
    end else if (!run) begin
      if (TxD_start) begin
        run <= 1'b1;
        sh <= {1'b1, TxD_data, 1'b0};
        cnt <= 16'(Div - 1);
        n <= '0;
      end
    end else if (cnt != '0) cnt <= cnt - 16'd1;
    else begin
      cnt <= 16'(Div - 1);
      n <= n + 4'd1;
      sh <= {1'b1, sh[9:1]};
      if (n == 4'd9) run <= 1'b0;
    end
endmodule

module serial_rxtx_fifo_leds #(
  parameter int ClkFrequency = 24000000,
  parameter int Baud = 115200,
  parameter int NumberOfLEDs = 2,
  parameter int FifoAddrBits = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    RxD,
  input  logic [1:0]              mode,
  output logic                    TxD,
  output logic [NumberOfLEDs-1:0] LED,
  output logic                    overflow,
  output logic [FifoAddrBits:0]   fifo_level
);
  localparam int DEPTH = 2 ** FifoAddrBits;
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, WAIT_BUSY = 2'd2, WAIT_DONE = 2'd3;
  logic rx_ready, tx_busy, tx_start, full, accept;
  logic [7:0] rx_data, tx_data, xf;
  logic [7:0] mem [DEPTH];
  logic [FifoAddrBits-1:0] wp, rp;
  logic [1:0] state;
  async_receiver #(.ClkFrequency(ClkFrequency), .Baud(Baud)) u_rx (
    .clk, .rst, .RxD, .RxD_data_ready(rx_ready), .RxD_data(rx_data)
  );
  async_transmitter #(.ClkFrequency(ClkFrequency), .Baud(Baud)) u_tx (
    .clk, .rst, .TxD_start(tx_start), .TxD_data(tx_data), .TxD, .TxD_busy(tx_busy)
  );
  always_comb begin
    xf = mode == 2'd0 ? rx_data + 8'd1 :
         mode == 2'd1 ? rx_data :
         mode == 2'd2 ? ((rx_data >= 8'h61 && rx_data <= 8'h7A) ? rx_data - 8'h20 : rx_data) :
         ~rx_data;
    tx_start = state == START;
    tx_data = mem[rp];
    full = fifo_level == (FifoAddrBits + 1)'(DEPTH);
    accept = rx_ready && (!full || tx_start);
  end
  always_ff @(posedge clk)
    if (accept) mem[wp] <= xf;
  // IDLE also waits out TxD_busy so a start can never overlap a frame
  always_ff @(posedge clk)
    if (rst) begin
      LED <= '0;
      overflow <= 1'b0;
      fifo_level <= '0;
      wp <= '0;
      rp <= '0;
      state <= IDLE;
    end else begin
      if (rx_ready) LED <= rx_data[NumberOfLEDs-1:0];
      if (rx_ready && !accept) overflow <= 1'b1;
      if (accept) wp <= wp + FifoAddrBits'(1);
      if (tx_start) rp <= rp + FifoAddrBits'(1);
      fifo_level <= (accept && !tx_start) ? fifo_level + (FifoAddrBits + 1)'(1) :
                    (tx_start && !accept) ? fifo_level - (FifoAddrBits + 1)'(1) : fifo_level;
      state <= state == IDLE ? ((fifo_level != '0 && !tx_busy) ? START : IDLE) :
               state == START ? WAIT_BUSY :
               state == WAIT_BUSY ? (tx_busy ? WAIT_DONE : WAIT_BUSY) :
               (tx_busy ? WAIT_DONE : IDLE);
    end
endmodule
